// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: widths, FSM state codes,
// ALU opcode encodings ({arit, ALUOp}) and the latched-command record.
package alu_sequencer_pkg;

  localparam int DATA_W = 4;
  localparam int REG_AW = 2;
  localparam int CNT_W  = 4;
  localparam int NREGS  = 1 << REG_AW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // {arit, ALUOp}
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOTA = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_CPLA = 3'b110;
  localparam logic [2:0] OP_CPLB = 3'b111;

  typedef struct packed {
    logic              arit;
    logic [1:0]        aluop;
    logic [REG_AW-1:0] rd;
  } issue_t;

endpackage

// File: rtl/alu_sequencer_regfile4x4.sv
// 4x4-bit register file: three combinational read ports, one synchronous
// write port, synchronous active-high clear.
module alu_sequencer_regfile4x4
  import alu_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  input  logic [REG_AW-1:0] raddr_dbg_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic [DATA_W-1:0] rdata_dbg_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o   = regs_q[raddr_a_i];
  assign rdata_b_o   = regs_q[raddr_b_i];
  assign rdata_dbg_o = regs_q[raddr_dbg_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle initiator for the external 4-bit ALU: accepts one command at a
// time, iterates the ALU with R fed back into A, and captures R and flags.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | cmd_ready=1, accept command, latch operands, write load imm
// ST_ISSUE | drive ALU, capture R/flags each cycle, count down iterations
// ST_DONE  | one-cycle done pulse, then back to ST_IDLE
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic              cmd_arit,
  input  logic [1:0]        cmd_aluop,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [CNT_W-1:0]  cmd_cnt,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [1:0]        alu_ALUOp,
  output logic              alu_arit,
  input  logic [DATA_W-1:0] alu_R,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_sign,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              flag_sign,
  output logic              flag_cacc,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [1:0]        state_q, state_d;
  issue_t            op_q, op_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              fzero_q, fzero_d;
  logic              fcarry_q, fcarry_d;
  logic              fsign_q, fsign_d;
  logic              fcacc_q, fcacc_d;

  logic              accept;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_ra_data;
  logic [DATA_W-1:0] rf_rb_data;

  alu_sequencer_regfile4x4 u_regfile (
    .clk         (clk),
    .reset       (reset),
    .we_i        (rf_we),
    .waddr_i     (rf_waddr),
    .wdata_i     (rf_wdata),
    .raddr_a_i   (cmd_ra),
    .raddr_b_i   (cmd_rb),
    .raddr_dbg_i (dbg_sel),
    .rdata_a_o   (rf_ra_data),
    .rdata_b_o   (rf_rb_data),
    .rdata_dbg_o (dbg_data)
  );

  assign accept = cmd_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    result_d = result_q;
    fzero_d  = fzero_q;
    fcarry_d = fcarry_q;
    fsign_d  = fsign_q;
    fcacc_d  = fcacc_q;
    rf_we    = 1'b0;
    rf_waddr = cmd_rd;
    rf_wdata = cmd_imm;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = cmd_cnt;
          first_d = 1'b1;
          if (cmd_load) begin
            rf_we    = 1'b1;
            result_d = cmd_imm;
            state_d  = ST_DONE;
          end else begin
            // Operands and op are only latched for ALU commands so the ALU
            // inputs keep their last issued values across loads.
            op_d    = '{arit: cmd_arit, aluop: cmd_aluop, rd: cmd_rd};
            opa_d   = rf_ra_data;
            opb_d   = rf_rb_data;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        rf_we    = 1'b1;
        rf_waddr = op_q.rd;
        rf_wdata = alu_R;
        result_d = alu_R;
        fzero_d  = alu_zero;
        fcarry_d = alu_carry;
        fsign_d  = alu_sign;
        fcacc_d  = (first_q ? 1'b0 : fcacc_q) | alu_carry;
        first_d  = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          opa_d = alu_R;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      result_q <= '0;
      fzero_q  <= 1'b0;
      fcarry_q <= 1'b0;
      fsign_q  <= 1'b0;
      fcacc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      result_q <= result_d;
      fzero_q  <= fzero_d;
      fcarry_q <= fcarry_d;
      fsign_q  <= fsign_d;
      fcacc_q  <= fcacc_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign alu_A      = opa_q;
  assign alu_B      = opb_q;
  assign alu_ALUOp  = op_q.aluop;
  assign alu_arit   = op_q.arit;
  assign result     = result_q;
  assign flag_zero  = fzero_q;
  assign flag_carry = fcarry_q;
  assign flag_sign  = fsign_q;
  assign flag_cacc  = fcacc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural 4-bit ALU attached
// and a command-level reference model of the register file and flags.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_load, cmd_arit;
  logic [1:0] cmd_aluop, cmd_rd, cmd_ra, cmd_rb, dbg_sel;
  logic [3:0] cmd_imm, cmd_cnt;
  logic [3:0] alu_A, alu_B, alu_R, result, dbg_data;
  logic [1:0] alu_ALUOp;
  logic       alu_arit, alu_zero, alu_carry, alu_sign;
  logic       done, flag_zero, flag_carry, flag_sign, flag_cacc;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_reg [4];
  logic [3:0] m_result;
  logic       m_z, m_c, m_s, m_cacc;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_arit(cmd_arit), .cmd_aluop(cmd_aluop), .cmd_rd(cmd_rd),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm), .cmd_cnt(cmd_cnt),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUOp(alu_ALUOp), .alu_arit(alu_arit),
    .alu_R(alu_R), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign),
    .done(done), .result(result), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .flag_sign(flag_sign), .flag_cacc(flag_cacc), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Behavioural ALU: returns {carry, zero, sign, R}; SUB carry means no borrow.
  function automatic logic [6:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    s = '0; r = '0; c = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOTA: r = ~a;
      OP_ADD:  begin s = {1'b0, a} + {1'b0, b};         r = s[3:0]; c = s[4]; end
      OP_SUB:  begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; r = s[3:0]; c = s[4]; end
      OP_CPLA: begin s = {1'b0, ~a} + 5'd1;             r = s[3:0]; c = s[4]; end
      OP_CPLB: begin s = {1'b0, ~b} + 5'd1;             r = s[3:0]; c = s[4]; end
      default: r = '0;
    endcase
    return {c, (r == 4'd0), r[3], r};
  endfunction

  assign {alu_carry, alu_zero, alu_sign, alu_R} = alu_fn({alu_arit, alu_ALUOp}, alu_A, alu_B);

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 4'd0;
    m_result = 4'd0; m_z = 1'b0; m_c = 1'b0; m_s = 1'b0; m_cacc = 1'b0;
  endtask

  // Drives one command, checks ALU drive per iteration, latency, done pulse and
  // final architectural state against the model. poke offers a second command
  // while busy, which must be ignored.
  task automatic run_cmd(input logic ld, input logic ar, input logic [1:0] op,
                         input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [3:0] imm, input logic [3:0] cnt, input bit poke);
    logic [3:0] a_seq [16];
    logic [3:0] a, b, r;
    logic [6:0] v;
    logic       cacc;
    int         n, exp_n;
    a = m_reg[ra]; b = m_reg[rb]; r = '0; v = '0; cacc = 1'b0;
    if (ld) begin
      exp_n = 0;
      m_reg[rd] = imm; m_result = imm;
    end else begin
      exp_n = int'(cnt) + 1;
      for (int i = 0; i <= int'(cnt); i++) begin
        a_seq[i] = a;
        v = alu_fn({ar, op}, a, b);
        r = v[3:0];
        cacc = cacc | v[6];
        a = r;
      end
      m_reg[rd] = r; m_result = r;
      m_c = v[6]; m_z = v[5]; m_s = v[4]; m_cacc = cacc;
    end

    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready); end
    cmd_load = ld; cmd_arit = ar; cmd_aluop = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    cmd_imm = imm; cmd_cnt = cnt; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    n = 0;
    while (!done && n < 40) begin
      if (!ld && n < exp_n) begin
        checks++;
        if (alu_A !== a_seq[n] || alu_B !== b || alu_ALUOp !== op || alu_arit !== ar) begin
          errors++;
          $display("FAIL alu_drive[%0d]: A=%h B=%h op=%b%b required A=%h B=%h op=%b%b",
                   n, alu_A, alu_B, alu_arit, alu_ALUOp, a_seq[n], b, ar, op);
        end
      end
      if (poke && n == 0) begin
        cmd_load = 1'b1; cmd_rd = rd; cmd_imm = ~imm; cmd_cnt = 4'd0; cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: cmd_ready=%b required 0", cmd_ready); end
      end
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (n != exp_n || done !== 1'b1) begin errors++; $display("FAIL latency: done after %0d cycles required %0d", n, exp_n); end
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_in_done: cmd_ready=%b required 0", cmd_ready); end
    checks++;
    if (result !== m_result || flag_zero !== m_z || flag_carry !== m_c || flag_sign !== m_s || flag_cacc !== m_cacc) begin
      errors++;
      $display("FAIL state: result=%h z=%b c=%b s=%b cacc=%b required result=%h z=%b c=%b s=%b cacc=%b",
               result, flag_zero, flag_carry, flag_sign, flag_cacc, m_result, m_z, m_c, m_s, m_cacc);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      checks++;
      if (dbg_data !== m_reg[i]) begin errors++; $display("FAIL regfile[%0d]: got %h required %h", i, dbg_data, m_reg[i]); end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL done_pulse: done=%b ready=%b required done=0 ready=1", done, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_arit = 1'b0; cmd_aluop = '0;
    cmd_rd = '0; cmd_ra = '0; cmd_rb = '0; cmd_imm = '0; cmd_cnt = '0; dbg_sel = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || result !== 4'd0) begin
      errors++; $display("FAIL reset_ctrl: ready=%b done=%b result=%h required 1 0 0", cmd_ready, done, result);
    end
    checks++;
    if ({flag_zero, flag_carry, flag_sign, flag_cacc} !== 4'b0 || alu_A !== 4'd0 || alu_B !== 4'd0 ||
        alu_ALUOp !== 2'd0 || alu_arit !== 1'b0) begin
      errors++; $display("FAIL reset_outs: flags=%b%b%b%b A=%h B=%h required zeros",
                         flag_zero, flag_carry, flag_sign, flag_cacc, alu_A, alu_B);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      checks++;
      if (dbg_data !== 4'd0) begin errors++; $display("FAIL reset_reg[%0d]: got %h required 0", i, dbg_data); end
    end
  endtask

  task automatic test_load();
    run_cmd(1'b1, 1'b0, 2'b00, 2'd0, 2'd0, 2'd0, 4'd5, 4'd0, 1'b0);
    run_cmd(1'b1, 1'b0, 2'b00, 2'd1, 2'd0, 2'd0, 4'd3, 4'd0, 1'b0);
    dbg_sel = 2'd0; #1;
    checks++;
    if (dbg_data !== 4'd5) begin errors++; $display("FAIL load_r0: got %h required 5", dbg_data); end
    dbg_sel = 2'd1; #1;
    checks++;
    if (dbg_data !== 4'd3) begin errors++; $display("FAIL load_r1: got %h required 3", dbg_data); end
    checks++;
    if ({flag_zero, flag_carry, flag_sign, flag_cacc} !== 4'b0) begin
      errors++; $display("FAIL load_flags: got %b%b%b%b required 0000", flag_zero, flag_carry, flag_sign, flag_cacc);
    end
  endtask

  task automatic test_add_sub();
    run_cmd(1'b0, 1'b1, 2'b00, 2'd2, 2'd0, 2'd1, 4'd0, 4'd0, 1'b0);
    checks++;
    if (result !== 4'd8 || flag_zero !== 1'b0 || flag_carry !== 1'b0 || flag_sign !== 1'b1 || flag_cacc !== 1'b0) begin
      errors++; $display("FAIL add: result=%h zcs=%b%b%b cacc=%b required 8 001 0",
                         result, flag_zero, flag_carry, flag_sign, flag_cacc);
    end
    run_cmd(1'b0, 1'b1, 2'b01, 2'd2, 2'd0, 2'd1, 4'd0, 4'd0, 1'b0);
    checks++;
    if (result !== 4'd2 || flag_zero !== 1'b0 || flag_carry !== 1'b1 || flag_sign !== 1'b0) begin
      errors++; $display("FAIL sub: result=%h zcs=%b%b%b required 2 010", result, flag_zero, flag_carry, flag_sign);
    end
    run_cmd(1'b0, 1'b1, 2'b01, 2'd2, 2'd1, 2'd1, 4'd0, 4'd0, 1'b0);
    checks++;
    if (result !== 4'd0 || flag_zero !== 1'b1) begin
      errors++; $display("FAIL sub_zero: result=%h z=%b required 0 1", result, flag_zero);
    end
  endtask

  task automatic test_repeat();
    run_cmd(1'b0, 1'b1, 2'b00, 2'd3, 2'd1, 2'd1, 4'd0, 4'd5, 1'b0);
    checks++;
    if (result !== 4'd5 || flag_carry !== 1'b0 || flag_cacc !== 1'b1) begin
      errors++; $display("FAIL repeat_add: result=%h c=%b cacc=%b required 5 0 1", result, flag_carry, flag_cacc);
    end
  endtask

  task automatic test_busy_ignored();
    run_cmd(1'b0, 1'b0, 2'b11, 2'd2, 2'd0, 2'd1, 4'd0, 4'd0, 1'b1);
    checks++;
    if (result !== 4'hA || flag_sign !== 1'b1) begin
      errors++; $display("FAIL not_a: result=%h s=%b required a 1", result, flag_sign);
    end
  endtask

  task automatic test_max_count();
    run_cmd(1'b1, 1'b0, 2'b00, 2'd1, 2'd0, 2'd0, 4'd1, 4'd0, 1'b0);
    run_cmd(1'b0, 1'b1, 2'b00, 2'd0, 2'd1, 2'd1, 4'd0, 4'd15, 1'b0);
    checks++;
    if (result !== 4'd1) begin errors++; $display("FAIL max_cnt: result=%h required 1", result); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      logic ld;
      ld = ($urandom_range(0, 2) == 0);
      run_cmd(ld, 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
              4'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) && !ld);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    run_cmd(1'b1, 1'b0, 2'b00, 2'd1, 2'd0, 2'd0, 4'd7, 4'd0, 1'b0);
    cmd_load = 1'b0; cmd_arit = 1'b1; cmd_aluop = 2'b00; cmd_rd = 2'd2; cmd_ra = 2'd1;
    cmd_rb = 2'd1; cmd_cnt = 4'd3; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || result !== 4'd0 ||
        {flag_zero, flag_carry, flag_sign, flag_cacc} !== 4'b0) begin
      errors++; $display("FAIL reset_mid_ctrl: ready=%b done=%b result=%h required 1 0 0", cmd_ready, done, result);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      checks++;
      if (dbg_data !== 4'd0) begin errors++; $display("FAIL reset_mid_reg[%0d]: got %h required 0", i, dbg_data); end
    end
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (done) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_done: %0d done pulses required 0", seen); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_add_sub();
    test_repeat();
    test_busy_ignored();
    test_max_count();
    test_back_to_back();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
